// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side types and the default fetch queue depth.
// The package keeps the historical name C so existing importers stay valid.
package C;

  // Default number of entries in the fetch queue.
  localparam int FETCH_QUEUE_DEPTH = 4;

  // One fetched instruction: its pc and the raw instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  // Read/write pointer for the default depth; the MSB is the wrap bit.
  typedef logic [$clog2(FETCH_QUEUE_DEPTH):0] fq_ptr_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: elastic in-order buffer between fetch and decode.
// Circular array with wrap-bit pointers; a flush drops every buffered entry.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards in_i straight to out_o when
// the queue is empty and decode is ready, giving a zero-cycle path.
module fetch_queue
  import C::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  fetch_data_t                in_i,
  input  logic                       in_i_valid,
  output logic                       in_i_ready,
  output fetch_data_t                out_o,
  output logic                       out_o_valid,
  input  logic                       out_o_ready,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t PtrOne = ptr_t'(1);

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  fetch_data_t mem_q [DEPTH];

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                 (wr_ptr_q[IW] != rd_ptr_q[IW]);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_i_valid && out_o_ready && !flush_i && !rst;
  assign out_o  = bypass ? in_i : mem_q[rd_ptr_q[IW-1:0]];
`else
  assign bypass = 1'b0;
  assign out_o  = mem_q[rd_ptr_q[IW-1:0]];
`endif

  // Ready ignores a same-cycle pop so out_o_ready never reaches in_i_ready.
  assign in_i_ready  = !full && !flush_i && !rst;
  assign out_o_valid = (!empty || bypass) && !flush_i && !rst;

  // A bypassed entry goes straight through and never touches the array.
  assign push = in_i_valid && in_i_ready && !bypass;
  assign pop  = out_o_valid && out_o_ready && !bypass;

  // The count is forced to zero while reset is asserted.
  assign count_o = rst ? '0 : (wr_ptr_q - rd_ptr_q);

  // Next-state pointer arithmetic; flush and reset both send pointers home.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rst || flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[IW-1:0]] <= in_i;
  end

`ifndef SYNTHESIS
  // Shadow sequence tags that prove every entry leaves in arrival order.
  logic [31:0] tag_q [DEPTH];
  logic [31:0] push_seq_q;
  logic [31:0] pop_seq_q;

  // Tag each entry on push and compare against the expected tag on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_seq_q <= '0;
      pop_seq_q  <= '0;
    end else if (flush_i) begin
      pop_seq_q <= push_seq_q;
    end else begin
      if (push) tag_q[wr_ptr_q[IW-1:0]] <= push_seq_q;
      if (push || bypass) push_seq_q <= push_seq_q + 32'd1;
      if (pop || bypass) pop_seq_q <= pop_seq_q + 32'd1;
      if (pop) begin
        a_order : assert (tag_q[rd_ptr_q[IW-1:0]] == pop_seq_q);
      end
    end
  end

  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    push |-> !full);

  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    pop |-> !empty);

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (out_o_valid && !out_o_ready && !flush_i) |=>
      (rst || flush_i || (out_o_valid && $stable(out_o))));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the fetch buffer.
module tb_fetch_queue;
  import C::*;

  localparam int DEPTH = FETCH_QUEUE_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  fetch_data_t     in_i;
  logic            in_i_valid;
  logic            in_i_ready;
  fetch_data_t     out_o;
  logic            out_o_valid;
  logic            out_o_ready;
  logic [CW-1:0]   count_o;

  fetch_data_t model_q [$];
  int compare_count  = 0;
  int mismatch_count = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_i        (in_i),
    .in_i_valid  (in_i_valid),
    .in_i_ready  (in_i_ready),
    .out_o       (out_o),
    .out_o_valid (out_o_valid),
    .out_o_ready (out_o_ready),
    .count_o     (count_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  function automatic fetch_data_t mkEntry(input logic [31:0] pc);
    fetch_data_t e;
    e.pc    = pc;
    e.instr = $urandom;
    return e;
  endfunction

  // Drive one cycle, check outputs mid-cycle against the model, then advance.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input fetch_data_t d, input logic rdy);
    logic        exp_ready;
    logic        exp_valid;
    logic        byp;
    fetch_data_t exp_out;
    int          size;
    rst         = r;
    flush_i     = f;
    in_i_valid  = v;
    in_i        = d;
    out_o_ready = rdy;
    @(negedge clk);
    size = model_q.size();
    byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = !r && !f && (size == 0) && v && rdy;
`endif
    exp_ready = !r && !f && (size < DEPTH);
    exp_valid = !r && !f && ((size > 0) || byp);
    exp_out   = (size > 0) ? model_q[0] : d;
    checkOutput("in_i_ready", 64'(in_i_ready), 64'(exp_ready));
    checkOutput("out_o_valid", 64'(out_o_valid), 64'(exp_valid));
    checkOutput("count_o", 64'(count_o), r ? 64'd0 : 64'(size));
    if (exp_valid) checkOutput("out_o", 64'(out_o), 64'(exp_out));
    if (r || f) begin
      model_q.delete();
    end else if (!byp) begin
      if (exp_valid && rdy) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios, then a random soak.
  initial begin
    fetch_data_t idle;
    idle = '0;

    // Reset for two cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b0);

    // Fill with decode stalled, then observe the full state.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, mkEntry(32'h8000_0000 + 32'(4 * i)), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b0);

    // Drain in order and confirm empty.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b0);

    // Streaming push+pop across the pointer wrap.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, mkEntry(32'h0000_1000 + 32'(4 * i)), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b0);

    // Full with pop: push refused, count drops to three.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, mkEntry(32'h0000_2000 + 32'(4 * i)), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, mkEntry(32'h0000_3000), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b0);

    // Flush with a concurrent offer, then confirm empty.
    applyStimulus(1'b0, 1'b1, 1'b1, mkEntry(32'h0000_4000), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1);

    // Empty-queue push with decode ready (bypass or one-cycle latency).
    applyStimulus(1'b0, 1'b0, 1'b1, mkEntry(32'h0000_0100), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b0);

    // Random traffic including occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      logic r;
      logic f;
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 19) == 0);
      applyStimulus(r, f, ($urandom_range(0, 9) < 7), mkEntry($urandom),
                    ($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count,
             mismatch_count);
    $finish;
  end

endmodule
